// File: rtl/io_sequencer_pkg.sv
// Shared state encoding and parameter defaults for the io_sequencer block.
package io_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLT_REQ  = 3'd1,
    FLT_WAIT = 3'd2,
    IMG_REQ  = 3'd3,
    IMG_WAIT = 3'd4,
    CNN_RUN  = 3'd5,
    FIN      = 3'd6
  } state_e;

  localparam logic [15:0] FLT_BASE_DEF = 16'h0000;
  localparam logic [15:0] IMG_BASE_DEF = 16'h4000;
  localparam int          TIMEOUT_DEF  = 1023;

  // States whose dwell time is bounded by the timeout counter.
  function automatic logic is_timed(input state_e s);
    return (s != IDLE) && (s != FIN);
  endfunction

endpackage

// File: rtl/io_sequencer_if.sv
// DMA and CNN handshake bundle; master is the sequencer, slave the DMA/CNN side.
interface io_sequencer_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
);
  logic              dma_req;
  logic              dma_ack;
  logic              dma_done;
  logic [ADDR_W-1:0] dma_addr;
  logic [CNT_W-1:0]  dma_len;
  logic              cnn_img;
  logic              decompressor_en;
  logic              cnn_start;
  logic              cnn_done;

  modport master (
    output dma_req, dma_addr, dma_len, cnn_img, decompressor_en, cnn_start,
    input  dma_ack, dma_done, cnn_done
  );

  modport slave (
    input  dma_req, dma_addr, dma_len, cnn_img, decompressor_en, cnn_start,
    output dma_ack, dma_done, cnn_done
  );
endinterface

// File: rtl/io_sequencer_timeout.sv
// Per-phase watchdog: reloads on load, counts down while en, expired at zero.
// Holds at zero so expired stays asserted until the next load.
module seq_timeout #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/io_sequencer.sv
// Job sequencer: filter DMA, image DMA, then one CNN run; stalls on dma_ack/dma_done/cnn_done.
// Each waiting phase is bounded by TIMEOUT cycles; abort and timeout both return to IDLE.
module io_sequencer
  import io_sequencer_pkg::*;
#(
  parameter int                CNT_W    = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] FLT_BASE = ADDR_W'(FLT_BASE_DEF),
  parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(IMG_BASE_DEF),
  parameter int                TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] flt_words,
  input  logic [CNT_W-1:0] img_words,
  input  logic             img_compressed,
  io_sequencer_if.master   bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flt_q, img_q;
  logic             comp_q;
  logic             first_q;
  logic             accept;
  logic             tmo;
  logic             load;
  logic             expired;
  logic             in_flt, in_img;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (flt_words != '0) ? FLT_REQ :
                    (img_words != '0) ? IMG_REQ : CNN_RUN;
        end
      end
      FLT_REQ: begin
        if (bus.dma_ack)  state_d = FLT_WAIT;
        else if (expired) tmo = 1'b1;
      end
      FLT_WAIT: begin
        if (bus.dma_done) state_d = (img_q != '0) ? IMG_REQ : CNN_RUN;
        else if (expired) tmo = 1'b1;
      end
      IMG_REQ: begin
        if (bus.dma_ack)  state_d = IMG_WAIT;
        else if (expired) tmo = 1'b1;
      end
      IMG_WAIT: begin
        if (bus.dma_done) state_d = CNN_RUN;
        else if (expired) tmo = 1'b1;
      end
      CNN_RUN: begin
        // A cnn_done coincident with the launch pulse belongs to no job of ours.
        if (bus.cnn_done && !first_q) state_d = FIN;
        else if (expired)             tmo = 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = IDLE;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      tmo     = 1'b0;
    end
  end

  assign load = (state_d != state_q) && is_timed(state_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flt_q   <= '0;
      img_q   <= '0;
      comp_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= load && (state_d == CNN_RUN);
      if (accept) begin
        flt_q  <= flt_words;
        img_q  <= img_words;
        comp_q <= img_compressed;
      end
    end
  end

  seq_timeout #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .en      (is_timed(state_q)),
    .expired (expired)
  );

  assign in_flt = (state_q == FLT_REQ) || (state_q == FLT_WAIT);
  assign in_img = (state_q == IMG_REQ) || (state_q == IMG_WAIT);

  assign bus.dma_req         = (state_q == FLT_REQ) || (state_q == IMG_REQ);
  assign bus.dma_addr        = in_flt ? FLT_BASE : (in_img ? IMG_BASE : '0);
  assign bus.dma_len         = in_flt ? flt_q : (in_img ? img_q : '0);
  assign bus.cnn_img         = in_img;
  assign bus.decompressor_en = in_img && comp_q;
  assign bus.cnn_start       = (state_q == CNN_RUN) && first_q;

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign error = tmo;

endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed scenarios, a vector table and randomized jobs
// checked against a transaction-level model of the job flow.
module tb_io_sequencer;

  localparam int CW = 16;
  localparam int AW = 16;
  localparam int T  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] flt_words = '0;
  logic [CW-1:0] img_words = '0;
  logic          img_compressed = 1'b0;
  logic          busy, done, error;

  io_sequencer_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

  io_sequencer #(.CNT_W(CW), .ADDR_W(AW), .TIMEOUT(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .flt_words      (flt_words),
    .img_words      (img_words),
    .img_compressed (img_compressed),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] len;
    logic        img;
    logic        dec;
  } xfer_t;

  typedef struct {
    logic [15:0] flt;
    logic [15:0] img;
    logic        comp;
    int          ack_d;
    int          dn_d;
    int          cnn_d;
  } job_t;

  typedef struct {
    job_t j;
    int   ntx;
    int   dn;
    int   er;
    int   cnn;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  xfer_t obs_q[$];
  int    n_cnn, n_done, n_err, n_req, n_dec, viol;
  int    done_cyc, cnn_done_cyc, cnn_start_cyc, err_cyc;
  bit    hung;
  logic [38:0] outs;

  assign outs = {bus.dma_req, bus.dma_addr, bus.dma_len, bus.cnn_img,
                 bus.decompressor_en, bus.cnn_start, busy, done, error};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plays DMA and CNN: acks/completes each phase after the job's delays,
  // counted in cycles from the first cycle of that phase.
  task automatic run_job(input job_t j);
    int req_cnt = 0;
    int wait_cnt = 0;
    int cnn_cnt = 0;
    bit waiting = 0;
    bit running = 0;
    bit was_wait;
    obs_q.delete();
    n_cnn = 0; n_done = 0; n_err = 0; n_req = 0; n_dec = 0; viol = 0;
    done_cyc = -1; cnn_done_cyc = -10; cnn_start_cyc = -1; err_cyc = -1;
    hung = 1'b1;
    @(negedge clk);
    flt_words = j.flt; img_words = j.img; img_compressed = j.comp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      bus.dma_ack = 1'b0; bus.dma_done = 1'b0; bus.cnn_done = 1'b0;
      if (!busy) begin
        hung = 1'b0;
        break;
      end
      was_wait = waiting;
      if (waiting) begin
        if (wait_cnt == j.dn_d) begin
          bus.dma_done = 1'b1;
          waiting = 1'b0;
        end
        wait_cnt++;
      end
      if (bus.dma_req) begin
        n_req++;
        if (req_cnt == j.ack_d) begin
          bus.dma_ack = 1'b1;
          waiting = 1'b1;
          wait_cnt = 0;
          obs_q.push_back({bus.dma_addr, bus.dma_len, bus.cnn_img, bus.decompressor_en});
        end
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
      if (bus.cnn_start) begin
        n_cnn++;
        if (cnn_start_cyc < 0) cnn_start_cyc = cyc;
        running = 1'b1;
        cnn_cnt = 0;
      end
      if (running) begin
        if (cnn_cnt == j.cnn_d) begin
          bus.cnn_done = 1'b1;
          running = 1'b0;
          cnn_done_cyc = cyc;
        end
        cnn_cnt++;
      end
      #1;
      if (done) begin n_done++; done_cyc = cyc; end
      if (error) begin n_err++; err_cyc = cyc; end
      if (bus.decompressor_en) n_dec++;
      if (bus.decompressor_en !== (bus.cnn_img & j.comp)) viol++;
      if (was_wait && (obs_q.size() > 0) &&
          ((bus.dma_req !== 1'b0) || (bus.dma_addr !== obs_q[$].addr) ||
           (bus.dma_len !== obs_q[$].len) || (bus.cnn_img !== obs_q[$].img))) viol++;
      @(negedge clk);
    end
    bus.dma_ack = 1'b0; bus.dma_done = 1'b0; bus.cnn_done = 1'b0;
    chk("job_terminates", hung, 1'b0);
  endtask

  // Transaction-level expectation: phases in order, each must respond within T cycles.
  task automatic model(input job_t j, output xfer_t eq[$], output int e_cnn,
                       output int e_done, output int e_err);
    bit ok = 1'b1;
    eq.delete();
    if (j.flt != 0) begin
      if (j.ack_d > T) ok = 1'b0;
      else begin
        eq.push_back({16'h0000, j.flt, 1'b0, 1'b0});
        if (j.dn_d > T) ok = 1'b0;
      end
    end
    if (ok && (j.img != 0)) begin
      if (j.ack_d > T) ok = 1'b0;
      else begin
        eq.push_back({16'h4000, j.img, 1'b1, j.comp});
        if (j.dn_d > T) ok = 1'b0;
      end
    end
    e_cnn = ok ? 1 : 0;
    if (ok && !((j.cnn_d >= 1) && (j.cnn_d <= T))) ok = 1'b0;
    e_done = ok ? 1 : 0;
    e_err  = ok ? 0 : 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    vec_t  vec[9];
    job_t  j;
    xfer_t eq[$];
    int    e_cnn, e_done, e_err, acc;

    bus.dma_ack = 1'b0; bus.dma_done = 1'b0; bus.cnn_done = 1'b0;
    #2;
    chk("reset_outputs", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_idle", outs, '0);

    // Two-transfer job with immediate DMA responses.
    j = '{16'd8, 16'd32, 1'b0, 0, 0, 1};
    run_job(j);
    chk("s46_xfer0", obs_q[0], {16'h0000, 16'd8, 1'b0, 1'b0});
    chk("s46_xfer1", obs_q[1], {16'h4000, 16'd32, 1'b1, 1'b0});
    chk("s46_cnn_starts", n_cnn, 1);
    chk("s46_done_after_cnn_done", done_cyc, cnn_done_cyc + 1);

    // Image-only compressed job: decompressor on for the IMG_REQ and IMG_WAIT cycles only.
    j = '{16'd0, 16'd5, 1'b1, 0, 0, 2};
    run_job(j);
    chk("s47_dec_cycles", n_dec, 2);
    chk("s47_dec_viol", viol, 0);

    j = '{16'd0, 16'd0, 1'b0, 0, 0, 2};
    run_job(j);
    chk("s48_cnn_start_cycle", cnn_start_cyc, 0);
    chk("s48_no_dma_req", n_req, 0);

    // DMA done withheld: the error fires on the tenth cycle after FLT_WAIT entry.
    j = '{16'd4, 16'd4, 1'b0, 0, 50, 1};
    run_job(j);
    chk("s49_err_cycle", err_cyc, 11);
    chk("s49_no_done", n_done, 0);

    vec[0] = '{'{16'd8, 16'd32, 1'b0, 0, 0, 1}, 2, 1, 0, 1};
    vec[1] = '{'{16'd0, 16'd5, 1'b1, 0, 0, 1}, 1, 1, 0, 1};
    vec[2] = '{'{16'd0, 16'd0, 1'b0, 0, 0, 3}, 0, 1, 0, 1};
    vec[3] = '{'{16'd3, 16'd4, 1'b1, 10, 10, 10}, 2, 1, 0, 1};
    vec[4] = '{'{16'd3, 16'd4, 1'b0, 11, 0, 1}, 0, 0, 1, 0};
    vec[5] = '{'{16'd3, 16'd4, 1'b0, 2, 11, 1}, 1, 0, 1, 0};
    vec[6] = '{'{16'd0, 16'd0, 1'b0, 0, 0, 0}, 0, 0, 1, 1};
    vec[7] = '{'{16'd0, 16'd0, 1'b0, 0, 0, 11}, 0, 0, 1, 1};
    vec[8] = '{'{16'd7, 16'd0, 1'b1, 1, 1, 2}, 1, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      run_job(vec[i].j);
      chk($sformatf("vec%0d_ntx", i), obs_q.size(), vec[i].ntx);
      chk($sformatf("vec%0d_done", i), n_done, vec[i].dn);
      chk($sformatf("vec%0d_err", i), n_err, vec[i].er);
      chk($sformatf("vec%0d_cnn", i), n_cnn, vec[i].cnn);
      chk($sformatf("vec%0d_viol", i), viol, 0);
    end

    // Abort in IMG_WAIT, then a stray dma_done, then a fresh job.
    @(negedge clk);
    flt_words = 16'd0; img_words = 16'd6; img_compressed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("s50_img_req", {bus.dma_req, bus.dma_addr, bus.decompressor_en}, {1'b1, 16'h4000, 1'b1});
    @(negedge clk);
    bus.dma_ack = 1'b1;
    @(negedge clk);
    bus.dma_ack = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("s50_abort_no_error", error, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("s50_idle_after_abort", outs, '0);
    @(negedge clk);
    bus.dma_done = 1'b1;
    #1;
    acc = {31'd0, done | error | busy};
    @(negedge clk);
    bus.dma_done = 1'b0;
    #1;
    acc = acc | {31'd0, done | error | busy};
    chk("s50_stray_ignored", acc, 0);
    j = '{16'd2, 16'd3, 1'b0, 1, 1, 1};
    run_job(j);
    chk("s50_restart_done", n_done, 1);

    // start while busy must not disturb the running CNN phase.
    @(negedge clk);
    flt_words = 16'd0; img_words = 16'd0; start = 1'b1;
    @(negedge clk);
    flt_words = 16'd5; img_words = 16'd5;
    #1;
    chk("busy_start_cnn_start", bus.cnn_start, 1'b1);
    @(negedge clk);
    start = 1'b0;
    bus.cnn_done = 1'b1;
    #1;
    chk("busy_start_ignored", {bus.dma_req, busy, bus.cnn_start}, {1'b0, 1'b1, 1'b0});
    @(negedge clk);
    bus.cnn_done = 1'b0;
    #1;
    chk("busy_start_fin", done, 1'b1);
    @(negedge clk);
    #1;
    chk("busy_start_back_idle", outs, '0);

    // Asynchronous reset in CNN_RUN discards the job.
    @(negedge clk);
    flt_words = 16'd0; img_words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("s51_async_reset_outs", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cnn_done = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      acc = acc | {31'd0, done | error | busy};
      @(negedge clk);
      bus.cnn_done = 1'b0;
    end
    chk("s51_no_done_after_reset", acc, 0);

    for (int i = 0; i < 40; i++) begin
      j.flt   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hffff));
      j.img   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hffff));
      j.comp  = 1'($urandom_range(0, 1));
      j.ack_d = $urandom_range(0, T + 1);
      j.dn_d  = $urandom_range(0, T + 1);
      j.cnn_d = $urandom_range(0, T + 1);
      model(j, eq, e_cnn, e_done, e_err);
      run_job(j);
      chk($sformatf("rnd%0d_ntx", i), obs_q.size(), eq.size());
      for (int k = 0; k < eq.size(); k++)
        chk($sformatf("rnd%0d_xfer%0d", i, k), obs_q[k], eq[k]);
      chk($sformatf("rnd%0d_cnn", i), n_cnn, e_cnn);
      chk($sformatf("rnd%0d_done", i), n_done, e_done);
      chk($sformatf("rnd%0d_err", i), n_err, e_err);
      chk($sformatf("rnd%0d_viol", i), viol, 0);
      if (e_done == 1)
        chk($sformatf("rnd%0d_done_timing", i), done_cyc, cnn_done_cyc + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
